// File: rtl/sound_event_scheduler_if.sv
// Bundle between the game logic / tone generators and the sound event scheduler.
// master = game side (drives events and generator waves), slave = the scheduler.
interface sound_event_scheduler_if;
    logic jumpForward;
    logic jumpBackward;
    logic jumpRight;
    logic jumpLeft;
    logic win;
    logic lose;
    logic jumpSoundIn;
    logic winSoundIn;
    logic loseSoundIn;
    logic enableJumpSound;
    logic enableWinSound;
    logic enableLoseSound;
    logic busy;
    logic sound;

    modport master (
        output jumpForward, jumpBackward, jumpRight, jumpLeft, win, lose,
        output jumpSoundIn, winSoundIn, loseSoundIn,
        input  enableJumpSound, enableWinSound, enableLoseSound, busy, sound
    );

    modport slave (
        input  jumpForward, jumpBackward, jumpRight, jumpLeft, win, lose,
        input  jumpSoundIn, winSoundIn, loseSoundIn,
        output enableJumpSound, enableWinSound, enableLoseSound, busy, sound
    );
endinterface

// File: rtl/sound_event_scheduler.sv
// Captures jump/win/lose edges, arbitrates lose > win > jump, times one generator enable
// at a time (with a silent gap after each sound) and registers the granted wave to the speaker.
module sound_event_scheduler #(
    parameter int JUMP_CYCLES = 2_500_000,
    parameter int WIN_CYCLES  = 25_000_000,
    parameter int LOSE_CYCLES = 20_000_000,
    parameter int GAP_CYCLES  = 250_000
) (
    input  logic                          clk,
    input  logic                          reset,
    sound_event_scheduler_if.slave        bus
);
    localparam int MAX_JW     = (JUMP_CYCLES > WIN_CYCLES) ? JUMP_CYCLES : WIN_CYCLES;
    localparam int MAX_LG     = (LOSE_CYCLES > GAP_CYCLES) ? LOSE_CYCLES : GAP_CYCLES;
    localparam int MAX_CYCLES = (MAX_JW > MAX_LG) ? MAX_JW : MAX_LG;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] JUMP_LOAD = CNT_W'(JUMP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LOAD  = CNT_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSE_LOAD = CNT_W'(LOSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP} state_e;
    typedef enum logic [1:0] {SEL_JUMP, SEL_WIN, SEL_LOSE} sel_e;

    state_e           state_q, state_d;
    sel_e             sel_q, sel_d;
    sel_e             grant_sel;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_jump_q, pend_jump_d;
    logic             pend_win_q, pend_win_d;
    logic             pend_lose_q, pend_lose_d;
    logic             en_jump_q, en_jump_d;
    logic             en_win_q, en_win_d;
    logic             en_lose_q, en_lose_d;
    logic             busy_q, busy_d;
    logic             sound_q, sound_d;
    logic [5:0]       lvl_q, lvl_d;
    logic [5:0]       rise;
    logic             jump_edge, win_edge, lose_edge, play_jump, grant;

    function automatic logic [CNT_W-1:0] load_for(input sel_e s);
        case (s)
            SEL_WIN:  return WIN_LOAD;
            SEL_LOSE: return LOSE_LOAD;
            default:  return JUMP_LOAD;
        endcase
    endfunction

    // Bit order {lose, win, jumpLeft, jumpRight, jumpBackward, jumpForward}.
    assign lvl_d     = {bus.lose, bus.win, bus.jumpLeft, bus.jumpRight,
                        bus.jumpBackward, bus.jumpForward};
    assign rise      = lvl_d & ~lvl_q;
    assign jump_edge = |rise[3:0];
    assign win_edge  = rise[4];
    assign lose_edge = rise[5];
    assign play_jump = (state_q == ST_PLAY) && (sel_q == SEL_JUMP);

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        pend_jump_d = pend_jump_q;
        pend_win_d  = pend_win_q;
        pend_lose_d = pend_lose_q;
        grant       = 1'b0;
        grant_sel   = SEL_JUMP;

        case (state_q)
            ST_IDLE: begin
                grant = pend_lose_q | pend_win_q | pend_jump_q;
                if (pend_lose_q)     grant_sel = SEL_LOSE;
                else if (pend_win_q) grant_sel = SEL_WIN;
            end
            ST_PLAY: begin
                if (play_jump && (pend_lose_q || pend_win_q)) begin
                    grant     = 1'b1;
                    grant_sel = pend_lose_q ? SEL_LOSE : SEL_WIN;
                end else if (play_jump && jump_edge) begin
                    cnt_d = JUMP_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant) begin
            state_d = ST_PLAY;
            sel_d   = grant_sel;
            cnt_d   = load_for(grant_sel);
            case (grant_sel)
                SEL_LOSE: pend_lose_d = 1'b0;
                SEL_WIN:  pend_win_d  = 1'b0;
                default:  pend_jump_d = 1'b0;
            endcase
        end

        // A jump edge while a jump is playing extends it instead of queueing another.
        pend_jump_d = pend_jump_d | (jump_edge & ~play_jump);
        pend_win_d  = pend_win_d  | win_edge;
        pend_lose_d = pend_lose_d | lose_edge;

        en_jump_d = (state_d == ST_PLAY) && (sel_d == SEL_JUMP);
        en_win_d  = (state_d == ST_PLAY) && (sel_d == SEL_WIN);
        en_lose_d = (state_d == ST_PLAY) && (sel_d == SEL_LOSE);
        busy_d    = (state_d != ST_IDLE);
        sound_d   = (en_jump_q & bus.jumpSoundIn) | (en_win_q & bus.winSoundIn)
                  | (en_lose_q & bus.loseSoundIn);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        lvl_q <= lvl_d;
        if (reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= SEL_JUMP;
            cnt_q       <= '0;
            pend_jump_q <= 1'b0;
            pend_win_q  <= 1'b0;
            pend_lose_q <= 1'b0;
            en_jump_q   <= 1'b0;
            en_win_q    <= 1'b0;
            en_lose_q   <= 1'b0;
            busy_q      <= 1'b0;
            sound_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            pend_jump_q <= pend_jump_d;
            pend_win_q  <= pend_win_d;
            pend_lose_q <= pend_lose_d;
            en_jump_q   <= en_jump_d;
            en_win_q    <= en_win_d;
            en_lose_q   <= en_lose_d;
            busy_q      <= busy_d;
            sound_q     <= sound_d;
        end
    end

    assign bus.enableJumpSound = en_jump_q;
    assign bus.enableWinSound  = en_win_q;
    assign bus.enableLoseSound = en_lose_q;
    assign bus.busy            = busy_q;
    assign bus.sound           = sound_q;
endmodule

// File: tb/tb_sound_event_scheduler.sv
// Directed bench for sound_event_scheduler with short durations (JUMP=8, WIN=16, LOSE=12, GAP=2).
// Outputs are packed as {enableJump, enableWin, enableLose, busy, sound} and sampled 1 ns after each edge.
module tb_sound_event_scheduler;
    localparam int JUMP = 8;
    localparam int WIN  = 16;
    localparam int LOSE = 12;
    localparam int GAP  = 2;

    typedef struct {
        logic [5:0] ev;   // {lose, win, jumpLeft, jumpRight, jumpBackward, jumpForward}
        logic [2:0] snd;  // {loseSoundIn, winSoundIn, jumpSoundIn}
        int         n;    // cycles the inputs are held; outputs checked after each edge
        logic [4:0] exp;  // {enJump, enWin, enLose, busy, sound}
        string      name;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t tbl[$];

    sound_event_scheduler_if bus();

    sound_event_scheduler #(
        .JUMP_CYCLES(JUMP),
        .WIN_CYCLES (WIN),
        .LOSE_CYCLES(LOSE),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic set_inputs(input logic [5:0] ev, input logic [2:0] snd);
        {bus.lose, bus.win, bus.jumpLeft, bus.jumpRight, bus.jumpBackward, bus.jumpForward} = ev;
        {bus.loseSoundIn, bus.winSoundIn, bus.jumpSoundIn} = snd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] outs();
        return {bus.enableJumpSound, bus.enableWinSound, bus.enableLoseSound, bus.busy, bus.sound};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b (enJ enW enL busy snd)", name, $time, act, exp);
        end
    endtask

    task automatic expect_cycles(input string name, input int n, input logic [4:0] exp);
        for (int i = 0; i < n; i++) begin
            step();
            check($sformatf("%s[%0d]", name, i), outs(), exp);
        end
    endtask

    initial begin
        // Single jump with wave passthrough, then simultaneous win + jump queued behind it.
        tbl.push_back('{6'b000000, 3'b000, 2,  5'b00000, "idle"});
        tbl.push_back('{6'b000001, 3'b000, 1,  5'b00000, "jump_capture"});
        tbl.push_back('{6'b000001, 3'b001, 1,  5'b10010, "jump_grant"});
        tbl.push_back('{6'b000001, 3'b001, 1,  5'b10011, "jump_snd_hi"});
        tbl.push_back('{6'b000001, 3'b000, 1,  5'b10010, "jump_snd_lo"});
        tbl.push_back('{6'b000000, 3'b001, 2,  5'b10011, "jump_snd_hi2"});
        tbl.push_back('{6'b000000, 3'b000, 2,  5'b10010, "jump_snd_lo2"});
        tbl.push_back('{6'b000000, 3'b001, 1,  5'b10011, "jump_last"});
        tbl.push_back('{6'b000000, 3'b000, 1,  5'b00010, "jump_gap1"});
        tbl.push_back('{6'b000000, 3'b001, 1,  5'b00010, "jump_gap2"});
        tbl.push_back('{6'b000000, 3'b001, 3,  5'b00000, "jump_idle"});
        tbl.push_back('{6'b010100, 3'b000, 1,  5'b00000, "winjump_capture"});
        tbl.push_back('{6'b010100, 3'b010, 1,  5'b01010, "win_grant"});
        tbl.push_back('{6'b010100, 3'b010, 15, 5'b01011, "win_play"});
        tbl.push_back('{6'b000000, 3'b000, 2,  5'b00010, "win_gap"});
        tbl.push_back('{6'b000000, 3'b000, 1,  5'b00000, "win_gap_idle"});
        tbl.push_back('{6'b000000, 3'b000, 8,  5'b10010, "queued_jump"});
        tbl.push_back('{6'b000000, 3'b000, 2,  5'b00010, "queued_jump_gap"});
        tbl.push_back('{6'b000000, 3'b000, 2,  5'b00000, "queued_jump_idle"});

        set_inputs(6'b000000, 3'b000);
        reset = 1'b1;
        repeat (3) step();
        check("reset_state", outs(), 5'b00000);
        reset = 1'b0;

        foreach (tbl[v]) begin
            set_inputs(tbl[v].ev, tbl[v].snd);
            expect_cycles(tbl[v].name, tbl[v].n, tbl[v].exp);
        end

        // Lose preempts a playing jump: enables swap in one edge, no gap between them.
        set_inputs(6'b000010, 3'b000);
        expect_cycles("pre_capture", 1, 5'b00000);
        expect_cycles("pre_jump", 4, 5'b10010);
        set_inputs(6'b100010, 3'b000);
        expect_cycles("pre_lose_capture", 1, 5'b10010);
        expect_cycles("pre_swap", 1, 5'b00110);
        expect_cycles("pre_lose_play", LOSE - 1, 5'b00110);
        expect_cycles("pre_gap", GAP, 5'b00010);
        set_inputs(6'b000000, 3'b000);
        expect_cycles("pre_idle", 3, 5'b00000);

        // Jump retrigger on the 4th play cycle: 4 + 8 = 12 enabled cycles, no second jump.
        set_inputs(6'b000001, 3'b000);
        expect_cycles("rt_capture", 1, 5'b00000);
        expect_cycles("rt_play", 4, 5'b10010);
        set_inputs(6'b001001, 3'b000);
        expect_cycles("rt_retrig", 1, 5'b10010);
        expect_cycles("rt_extend", JUMP - 1, 5'b10010);
        expect_cycles("rt_gap", GAP, 5'b00010);
        set_inputs(6'b000000, 3'b000);
        expect_cycles("rt_idle", 3, 5'b00000);

        // Lose during win is not a preemption: win + gap, idle edge, then lose.
        set_inputs(6'b010000, 3'b000);
        expect_cycles("wl_capture", 1, 5'b00000);
        expect_cycles("wl_win_a", 4, 5'b01010);
        set_inputs(6'b110000, 3'b000);
        expect_cycles("wl_win_b", WIN - 4, 5'b01010);
        expect_cycles("wl_gap", GAP, 5'b00010);
        expect_cycles("wl_idle", 1, 5'b00000);
        expect_cycles("wl_lose", LOSE, 5'b00110);
        set_inputs(6'b000000, 3'b000);
        expect_cycles("wl_gap2", GAP, 5'b00010);
        expect_cycles("wl_idle2", 2, 5'b00000);

        // Reset mid-lose with a jump pending; win rises while reset is held.
        set_inputs(6'b100000, 3'b100);
        expect_cycles("rs_capture", 1, 5'b00000);
        expect_cycles("rs_grant", 1, 5'b00110);
        expect_cycles("rs_lose", 2, 5'b00111);
        set_inputs(6'b100100, 3'b100);
        expect_cycles("rs_jump_pend", 1, 5'b00111);
        reset = 1'b1;
        set_inputs(6'b110100, 3'b100);
        expect_cycles("rs_reset", 2, 5'b00000);
        reset = 1'b0;
        expect_cycles("rs_after", 6, 5'b00000);
        set_inputs(6'b000000, 3'b000);
        expect_cycles("rs_release", 2, 5'b00000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
